// File: rtl/shift_digit_pipe.sv
// Digit-granular shifter: one registered log-barrel stage per shift bit, SHIFT_W cycles of latency.
// A single global stall freezes every stage whenever the output holds an unconsumed result.
module shift_digit_pipe #(
  parameter int WIDTH     = 50,
  parameter int STEP      = 5,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  input  logic [STEP-1:0]    in_fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_range_ok
);

  localparam int DIGITS = WIDTH / STEP;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_LSL = 2'b11;

  if (WIDTH % STEP != 0) begin : g_bad_width
    $error("shift_digit_pipe: WIDTH must be a multiple of STEP");
  end
  if (MAX_SHIFT >= (1 << SHIFT_W)) begin : g_bad_max_shift
    $error("shift_digit_pipe: MAX_SHIFT must be below 2**SHIFT_W");
  end

  // Moves the word by amt digits. Right shifts and left shifts both take the
  // captured fill digit, so the arithmetic mode needs no special case here.
  function automatic logic [WIDTH-1:0] shift_digits(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic [STEP-1:0]  fill,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    int               src;
    int               rot;
    r   = '0;
    rot = amt % DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
      case (mode)
        MODE_ROR: begin
          src = (i + rot) % DIGITS;
          r[i*STEP +: STEP] = d[src*STEP +: STEP];
        end
        MODE_LSL: begin
          src = (i >= amt) ? (i - amt) : 0;
          r[i*STEP +: STEP] = (i >= amt) ? d[src*STEP +: STEP] : fill;
        end
        default: begin
          src = (i + amt < DIGITS) ? (i + amt) : 0;
          r[i*STEP +: STEP] = (i + amt < DIGITS) ? d[src*STEP +: STEP] : fill;
        end
      endcase
    end
    return r;
  endfunction

  logic [WIDTH-1:0]   data_q  [SHIFT_W];
  logic [WIDTH-1:0]   data_d  [SHIFT_W];
  logic [SHIFT_W-1:0] shift_q [SHIFT_W];
  logic [SHIFT_W-1:0] shift_d [SHIFT_W];
  logic [1:0]         mode_q  [SHIFT_W];
  logic [1:0]         mode_d  [SHIFT_W];
  logic [STEP-1:0]    fill_q  [SHIFT_W];
  logic [STEP-1:0]    fill_d  [SHIFT_W];
  logic [SHIFT_W-1:0] vld_q, vld_d;
  logic [SHIFT_W-1:0] rok_q, rok_d;

  logic advance;

  assign advance      = !vld_q[SHIFT_W-1] || out_ready;
  assign in_ready     = advance;
  assign out_valid    = vld_q[SHIFT_W-1];
  assign out_data     = data_q[SHIFT_W-1];
  assign out_range_ok = rok_q[SHIFT_W-1];

  always_comb begin
    logic [WIDTH-1:0]   s_data;
    logic [SHIFT_W-1:0] s_shift;
    logic [1:0]         s_mode;
    logic [STEP-1:0]    s_fill;
    logic               s_vld;
    logic               s_rok;
    vld_d = '0;
    rok_d = '0;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (k == 0) begin
        s_data  = in_data;
        s_shift = in_shift;
        s_mode  = in_mode;
        // Arithmetic mode replicates the sign digit instead of the supplied fill.
        s_fill  = (in_mode == MODE_ASR) ? in_data[WIDTH-1 -: STEP] : in_fill;
        s_vld   = in_valid;
        s_rok   = (in_shift <= MAX_SHIFT_V);
      end else begin
        s_data  = data_q[k-1];
        s_shift = shift_q[k-1];
        s_mode  = mode_q[k-1];
        s_fill  = fill_q[k-1];
        s_vld   = vld_q[k-1];
        s_rok   = rok_q[k-1];
      end
      data_d[k]  = s_shift[k] ? shift_digits(s_data, s_mode, s_fill, 1 << k) : s_data;
      shift_d[k] = s_shift;
      mode_d[k]  = s_mode;
      fill_d[k]  = s_fill;
      vld_d[k]   = s_vld;
      rok_d[k]   = s_rok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rok_q <= '1;
      for (int k = 0; k < SHIFT_W; k++) begin
        data_q[k]  <= '0;
        shift_q[k] <= '0;
        mode_q[k]  <= MODE_LSR;
        fill_q[k]  <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      rok_q <= rok_d;
      for (int k = 0; k < SHIFT_W; k++) begin
        data_q[k]  <= data_d[k];
        shift_q[k] <= shift_d[k];
        mode_q[k]  <= mode_d[k];
        fill_q[k]  <= fill_d[k];
      end
    end
  end

endmodule

// File: doc/shift_digit_pipe.md
Name: shift_digit_pipe

Overview:
- Parametrised, pipelined successor to the combinational digit-granular shifter.
- Shifts a WIDTH-bit word by an integer number of STEP-bit digits.
- Supports four modes: logical right with fill, rotate right, arithmetic right, and logical left with fill.
- Uses a valid/ready handshake on both sides, one log-barrel stage per shift bit, a register after every stage, and a range flag that travels with each result.
- Sits between datapath producers and consumers that need shifts at full throughput with backpressure.

Parameters:
- WIDTH, 50: data width in bits; must be an exact multiple of STEP.
- STEP, 5: digit width in bits; also the fill width.
- SHIFT_W, 3: shift amount width; equals the number of pipeline stages.
- MAX_SHIFT, 4: largest shift amount that sets out_range_ok; must be < 2^SHIFT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  word to shift.
- in_shift  in  SHIFT_W  shift amount, in digits.
- in_mode  in  2  00 logical right, 01 rotate right, 10 arithmetic right, 11 logical left.
- in_fill  in  STEP  digit pattern inserted in modes 00 and 11.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted word.
- out_range_ok  out  1  1 when the transaction's in_shift <= MAX_SHIFT.

Behaviour:
- DIGITS = WIDTH/STEP. Digit i is bits [i*STEP +: STEP].
- Accept condition: in_valid & in_ready.
- Captured with each accepted transaction:
  - in_data, in_mode, in_shift.
  - range_ok = (in_shift <= MAX_SHIFT).
  - fill digit:
    - modes 00 and 11: in_fill.
    - mode 10: top digit of in_data (sign digit).
    - mode 01: unused.
- Stage k (k = 0..SHIFT_W-1): if shift bit k is 1, move the word by 2^k digits; otherwise pass it through. Each stage result is registered.
- Mode 00: out digit i = in digit i+s when i+s < DIGITS, else the fill digit.
- Mode 10: same as mode 00, but the fill digit is the captured sign digit.
- Mode 11: out digit i = in digit i-s when i >= s, else the fill digit.
- Mode 01: out digit i = in digit (i+s) mod DIGITS. Stage k rotates by 2^k mod DIGITS; composing the stages gives rotation by s mod DIGITS.
- s >= DIGITS:
  - modes 00 and 11: every digit equals the fill digit.
  - mode 10: every digit equals the sign digit.
  - mode 01: rotation wraps as above.
- out_range_ok does not alter the data. The shift is performed for every in_shift value.
- Latency: a result appears on out_valid exactly SHIFT_W cycles after acceptance when there is no stall.
- Throughput: one transaction per cycle.
- Flow control is a global stall:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - All stage registers and valid bits load only when advance = 1.
  - While stalled, out_data and out_range_ok hold stable and are never overwritten.
- Bubbles: an empty stage (valid bit 0) still advances. Transactions are never dropped, duplicated or reordered.
- Simultaneous accept and output handshake in the same cycle is legal and keeps full rate.
- Reset (asynchronous, any time including mid-flight):
  - All stage valid bits = 0, so out_valid = 0.
  - out_data = 0, out_range_ok = 1.
  - Every in-flight transaction is discarded.
  - in_ready = 1 from the first cycle after release.
- Invalid parameterisation (WIDTH % STEP != 0, or MAX_SHIFT >= 2^SHIFT_W) must trigger an elaboration-time error.

Test Plan:
In all scenarios, digit i of in_data holds the value i.
- Logical right, default parameters: in_shift=2, mode 00, fill=5'h1F, out_ready=1 -> 3 cycles later out_valid=1; digits 0..7 = 2..9; digits 8,9 = 5'h1F; out_range_ok=1.
- Out of range: in_shift=5, mode 00, fill=0 -> digits 0..4 = 5..9; digits 5..9 = 0; out_range_ok=0. Separately, in_shift=7, mode 01 -> digit i = (i+7) mod 10; out_range_ok=0.
- Arithmetic: top digit forced to 5'h15, in_shift=3, mode 10 -> digits 7..9 = 5'h15; digits 0..6 = in digits 3..9. Separately, mode 11, in_shift=1, fill=5'h0A -> digit 0 = 5'h0A; digit i = i-1 for i >= 1.
- Backpressure: 6 back-to-back transactions with shift values 0..5, out_ready held low for 5 cycles after the first out_valid -> in_ready=0 while stalled; out_data stays stable; all 6 results arrive in order with correct data and range flags; none lost or duplicated.
- Bubbles: in_valid asserted every other cycle, out_ready=1 -> out_valid toggles with a 3-cycle offset; each result matches its input.
- Reset mid-flight: rst_n pulsed low with 3 transactions in flight -> out_valid=0 and out_data=0 immediately; none of those 3 results ever appears; a new transaction accepted after release completes in 3 cycles.
